branch_history_table: RTL

Dynamic branch predictor for the RISC-V core: a table of 2-bit saturating counters, optionally gshare-indexed, read with the fetch PC and trained with the ALU's resolved `Branch_Enable` in execute. It sits downstream of the ALU/ALUControl pair, consuming the branch outcome, and feeds the fetch stage's next-PC select and the pipeline flush logic. It also keeps saturating branch and mispredict counts for performance measurement.

---
 rtl/branch_history_table_pkg.sv | 17 +
 rtl/branch_history_table_sat_counter2.sv | 19 +
 rtl/branch_history_table.sv | 116 +++++++++++
 3 files changed

// File: rtl/branch_history_table_pkg.sv
// Shared definitions for the branch history table: 2-bit counter encodings
// and the saturating statistics helper.
package branch_history_table_pkg;

  localparam logic [1:0] BHT_SNT   = 2'b00;
  localparam logic [1:0] BHT_WNT   = 2'b01;
  localparam logic [1:0] BHT_WT    = 2'b10;
  localparam logic [1:0] BHT_ST    = 2'b11;
  localparam logic [1:0] BHT_RESET = BHT_WNT;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
    sat_inc32 = (en && (value != STAT_MAX)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// Combinational next-state of a 2-bit saturating branch counter.
module sat_counter2
  import branch_history_table_pkg::*;
(
  input  logic [1:0] count,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = count;
    if (taken) begin
      if (count != BHT_ST) next = count + 2'd1;
    end else begin
      if (count != BHT_SNT) next = count - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Bimodal / gshare branch predictor with 2-bit counters, write-first bypass
// and saturating branch / mispredict statistics.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int HIST_BITS  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  predict_valid,
  output logic                  predict_taken,
  input  logic                  update_valid,
  input  logic [31:0]           update_pc,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_predicted,
  input  logic                  branch_enable,
  output logic                  mispredict,
  output logic [INDEX_BITS-1:0] lookup_index,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int GW      = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic [1:0]            table_q [ENTRIES];
  logic [GW-1:0]         ghr_q, ghr_d;
  logic [INDEX_BITS-1:0] hist_term;
  logic [INDEX_BITS-1:0] cur_index;
  logic [1:0]            upd_cur, upd_next, lookup_cnt;

  logic                  predict_valid_q, predict_valid_d;
  logic                  predict_taken_q, predict_taken_d;
  logic [INDEX_BITS-1:0] lookup_index_q, lookup_index_d;
  logic [31:0]           branch_count_q, branch_count_d;
  logic [31:0]           mispredict_count_q, mispredict_count_d;

  // update_pc is carried for debug visibility only
  logic unused_bits;
  assign unused_bits = ^{update_pc, lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0]};

  generate
    if (HIST_BITS == 0) begin : g_bimodal
      assign hist_term = '0;
      assign ghr_d     = ghr_q;
    end else begin : g_gshare
      always_comb begin
        hist_term                = '0;
        hist_term[HIST_BITS-1:0] = ghr_q;
      end
      if (HIST_BITS == 1) begin : g_h1
        assign ghr_d = update_valid ? branch_enable : ghr_q;
      end else begin : g_hn
        assign ghr_d = update_valid ? {ghr_q[HIST_BITS-2:0], branch_enable} : ghr_q;
      end
    end
  endgenerate

  assign cur_index = lookup_pc[INDEX_BITS+1:2] ^ hist_term;
  assign upd_cur   = table_q[update_index];

  sat_counter2 u_sat (
    .count (upd_cur),
    .taken (branch_enable),
    .next  (upd_next)
  );

  // Write-first: a lookup hitting the entry being trained sees the new value
  assign lookup_cnt = (update_valid && (update_index == cur_index)) ? upd_next
                                                                    : table_q[cur_index];
  assign mispredict = update_valid & (update_predicted ^ branch_enable);

  always_comb begin
    predict_valid_d    = lookup_valid;
    predict_taken_d    = lookup_valid & lookup_cnt[1];
    lookup_index_d     = lookup_valid ? cur_index : lookup_index_q;
    branch_count_d     = sat_inc32(branch_count_q, update_valid);
    mispredict_count_d = sat_inc32(mispredict_count_q, mispredict);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= BHT_RESET;
    end else if (update_valid) begin
      table_q[update_index] <= upd_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q              <= '0;
      predict_valid_q    <= 1'b0;
      predict_taken_q    <= 1'b0;
      lookup_index_q     <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      ghr_q              <= ghr_d;
      predict_valid_q    <= predict_valid_d;
      predict_taken_q    <= predict_taken_d;
      lookup_index_q     <= lookup_index_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign predict_valid    = predict_valid_q;
  assign predict_taken    = predict_taken_q;
  assign lookup_index     = lookup_index_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
